// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: issues one AXI4 INCR read burst per cache miss and streams the returned beats into the cache refill port.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE_BITS = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    miss,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic [DATA_WIDTH/8-1:0] mem_wstb,
  output logic                    mem_data_valid,
  output logic                    mem_last,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    busy,
  output logic                    err_slverr,
  output logic                    err_last,
  output logic [15:0]             refill_count
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BEATS = (2 ** LINE_SIZE_BITS) / BYTES;
  localparam logic [7:0] LAST = 8'(BEATS - 1);
  if (DATA_WIDTH % 8 != 0 || BEATS < 1 || BEATS > 256) begin : g_bad_cfg
    $error("cache_refill_ctrl: DATA_WIDTH/LINE_SIZE_BITS give an illegal beat count");
  end
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [ADDR_WIDTH-1:0] line_base;
  logic hs, done;
  assign m_axi_arlen = LAST;
  assign m_axi_arsize = 3'($clog2(BYTES));
  assign m_axi_arburst = 2'b01;
  assign m_axi_araddr = line_base;
  assign hs = m_axi_rvalid & m_axi_rready;
  assign done = hs && cnt == LAST;
  always_comb begin
    state_nx = state;
    m_axi_arvalid = state == ADDR;
    m_axi_rready = state == DATA;
    busy = state != IDLE;
    case (state)
      IDLE:    state_nx = miss ? ADDR : IDLE;
      ADDR:    state_nx = m_axi_arready ? DATA : ADDR;
      DATA:    state_nx = done ? DRAIN : DATA;
      DRAIN:   state_nx = miss ? DRAIN : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_base <= '0;
      cnt <= '0;
      mem_addr <= '0;
      mem_data_in <= '0;
      mem_wstb <= '0;
      mem_data_valid <= 1'b0;
      mem_last <= 1'b0;
      err_slverr <= 1'b0;
      err_last <= 1'b0;
      refill_count <= '0;
    end else begin
      if (state == IDLE && miss) line_base <= {cpu_addr[ADDR_WIDTH-1:LINE_SIZE_BITS], {LINE_SIZE_BITS{1'b0}}};
      mem_data_valid <= hs;
      mem_last <= done;
      mem_wstb <= {BYTES{hs}};
      if (hs) begin
        mem_data_in <= m_axi_rdata;
        mem_addr <= line_base + ADDR_WIDTH'(cnt) * ADDR_WIDTH'(BYTES);
        cnt <= done ? 8'd0 : cnt + 8'd1;
        if (m_axi_rlast != (cnt == LAST)) err_last <= 1'b1;
        if (m_axi_rresp[1]) err_slverr <= 1'b1;
      end
      if (done) refill_count <= refill_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized AXI read-slave stimulus checked against a line/beat arithmetic model.
module tb_cache_refill_ctrl;
  logic clk = 0, reset_n = 0, miss = 0;
  logic [31:0] cpu_addr = 0, mem_addr, mem_data_in, m_axi_araddr, m_axi_rdata = 0;
  logic [3:0] mem_wstb;
  logic mem_data_valid, mem_last, m_axi_arvalid, m_axi_rready, busy, err_slverr, err_last;
  logic m_axi_arready = 0, m_axi_rlast = 0, m_axi_rvalid = 0;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst, m_axi_rresp = 0;
  logic [15:0] refill_count;
  int checks = 0, failures = 0;
  logic [15:0] exp_count = 0;
  bit exp_err_last = 0, exp_err_slv = 0;

  cache_refill_ctrl dut (
    .clk(clk), .reset_n(reset_n), .miss(miss), .cpu_addr(cpu_addr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wstb(mem_wstb),
    .mem_data_valid(mem_data_valid), .mem_last(mem_last),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .busy(busy),
    .err_slverr(err_slverr), .err_last(err_last), .refill_count(refill_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({m_axi_arvalid, m_axi_rready, mem_data_valid, mem_last, busy, err_slverr, err_last} !== 7'b0 ||
        refill_count !== 16'h0 || mem_addr !== 32'h0 || mem_data_in !== 32'h0 || mem_wstb !== 4'h0 || m_axi_araddr !== 32'h0) begin
      failures++;
      $display("FAIL %s: arv=%b rr=%b dv=%b last=%b busy=%b slv=%b el=%b cnt=%h maddr=%h mdata=%h wstb=%h araddr=%h, expected all zero",
               name, m_axi_arvalid, m_axi_rready, mem_data_valid, mem_last, busy, err_slverr, err_last,
               refill_count, mem_addr, mem_data_in, mem_wstb, m_axi_araddr);
    end
  endtask

  // mode: 0 = rvalid always high, 1 = rvalid toggles, 2 = random rvalid
  task automatic do_refill(input logic [31:0] addr, input int mode, input int ar_delay,
                           input int rlast_beat, input int slv_beat, input int abort_beat, input string name);
    logic [31:0] base, d;
    int n, cyc;
    bit rv, hs;
    base = addr & ~32'h7F;
    n = 0;
    cpu_addr = addr;
    miss = 1;
    cyc = 0;
    step();
    while (!m_axi_arvalid && cyc < 20) begin
      step();
      cyc++;
    end
    checks++;
    if (m_axi_arvalid !== 1'b1) begin
      failures++;
      $display("FAIL %s ar_timeout: arvalid=%b expected 1", name, m_axi_arvalid);
      miss = 0;
      return;
    end
    checks++;
    if (m_axi_araddr !== base || m_axi_arlen !== 8'd31 || m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'd1 || m_axi_rready !== 1'b0) begin
      failures++;
      $display("FAIL %s ar_fields: araddr=%h len=%0d size=%0d burst=%0d rready=%b expected %h 31 2 1 0",
               name, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready, base);
    end
    for (int i = 0; i < ar_delay; i++) begin
      m_axi_arready = 0;
      step();
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== base || m_axi_rready !== 1'b0) begin
        failures++;
        $display("FAIL %s ar_stall%0d: arvalid=%b araddr=%h rready=%b expected 1 %h 0", name, i, m_axi_arvalid, m_axi_araddr, m_axi_rready, base);
      end
    end
    m_axi_arready = 1;
    step();
    m_axi_arready = 0;
    checks++;
    if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b1) begin
      failures++;
      $display("FAIL %s ar_done: arvalid=%b rready=%b expected 0 1", name, m_axi_arvalid, m_axi_rready);
    end
    cyc = 0;
    while (n < 32 && cyc < 400) begin
      rv = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      d = $urandom;
      m_axi_rvalid = rv;
      m_axi_rdata = d;
      m_axi_rlast = n == rlast_beat;
      m_axi_rresp = n == slv_beat ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
      hs = rv && m_axi_rready;
      step();
      checks++;
      if (mem_data_valid !== hs || (!hs && mem_last !== 1'b0)) begin
        failures++;
        $display("FAIL %s valid beat%0d: mem_data_valid=%b mem_last=%b expected %b 0", name, n, mem_data_valid, mem_last, hs);
      end
      if (hs) begin
        checks++;
        if (mem_addr !== base + 32'(n * 4) || mem_data_in !== d || mem_last !== (n == 31) || mem_wstb !== 4'hF) begin
          failures++;
          $display("FAIL %s beat%0d: addr=%h data=%h last=%b wstb=%h expected %h %h %b f",
                   name, n, mem_addr, mem_data_in, mem_last, mem_wstb, base + 32'(n * 4), d, n == 31);
        end
        if ((n == rlast_beat) != (n == 31)) exp_err_last = 1;
        if (n == slv_beat) exp_err_slv = 1;
        if (n == abort_beat) begin
          reset_n = 0;
          #1;
          check_idle_outputs({name, " abort"});
          exp_count = 0;
          exp_err_last = 0;
          exp_err_slv = 0;
          m_axi_rvalid = 0;
          m_axi_rlast = 0;
          m_axi_rresp = 0;
          miss = 0;
          #2 reset_n = 1;
          step();
          return;
        end
        n++;
      end
      cyc++;
    end
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    m_axi_rresp = 0;
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL %s r_timeout: beats=%0d expected 32", name, n);
    end
    exp_count = exp_count + 16'd1;
    checks++;
    if (m_axi_rready !== 1'b0 || busy !== 1'b1 || refill_count !== exp_count || err_last !== exp_err_last || err_slverr !== exp_err_slv) begin
      failures++;
      $display("FAIL %s end: rready=%b busy=%b count=%h err_last=%b err_slverr=%b expected 0 1 %h %b %b",
               name, m_axi_rready, busy, refill_count, err_last, err_slverr, exp_count, exp_err_last, exp_err_slv);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b1 || m_axi_arvalid !== 1'b0 || mem_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s stale_miss: busy=%b arvalid=%b valid=%b expected 1 0 0", name, busy, m_axi_arvalid, mem_data_valid);
    end
    miss = 0;
    step();
    checks++;
    if (busy !== 1'b0 || refill_count !== exp_count) begin
      failures++;
      $display("FAIL %s drain: busy=%b count=%h expected 0 %h", name, busy, refill_count, exp_count);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    step();
    step();
    check_idle_outputs("reset");
    checks++;
    if (m_axi_arlen !== 8'd31 || m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'd1) begin
      failures++;
      $display("FAIL reset_consts: len=%0d size=%0d burst=%0d expected 31 2 1", m_axi_arlen, m_axi_arsize, m_axi_arburst);
    end
    reset_n = 1;
    step();
  endtask

  task automatic test_basic();
    do_refill(32'h0000_1234, 0, 0, 31, -1, -1, "basic");
  endtask

  task automatic test_ar_stall();
    do_refill($urandom, 0, 5, 31, -1, -1, "ar_stall");
  endtask

  task automatic test_toggle();
    do_refill($urandom, 1, 0, 31, -1, -1, "toggle");
  endtask

  task automatic test_rlast_err();
    do_refill($urandom, 0, 1, 10, -1, -1, "rlast_err");
  endtask

  task automatic test_slverr();
    do_refill($urandom, 2, 0, 31, 5, -1, "slverr");
    do_refill($urandom, 0, 0, 31, -1, 20, "abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_refill($urandom, 2, $urandom_range(0, 3), 31, -1, -1, "random");
  endtask

  task automatic test_wrap();
    force dut.refill_count = 16'hFFFF;
    #1 release dut.refill_count;
    exp_count = 16'hFFFF;
    checks++;
    if (refill_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preset: count=%h expected ffff", refill_count);
    end
    do_refill($urandom, 0, 0, 31, -1, -1, "wrap");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_stall();
    test_toggle();
    test_rlast_err();
    test_slverr();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
